// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor resolving CHUNK bits per clock with a start/done handshake.
// Optional signed saturation of the result is compiled in when SATURATE_EN is defined.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [WIDTH-1:0] res_next, sum_next, b_eff;
  logic             carry_reg, sa_reg, sb_reg;
  logic [CW-1:0]    cnt_reg;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk, raw_ov;

  assign b_eff      = sub ? ~b : b;
  assign last_chunk = (cnt_reg == LAST);
  assign chunk_sum  = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_reg};

  // Each chunk result enters at the top so the LS chunk ends up at the bottom after N shifts.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign res_next = chunk_sum[CHUNK-1:0];
    end else begin : g_multi
      assign res_next = {chunk_sum[CHUNK-1:0], res_reg[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign raw_ov = (sa_reg == sb_reg) && (res_next[WIDTH-1] != sa_reg);

`ifdef SATURATE_EN
  assign sum_next = raw_ov ? {sa_reg, {(WIDTH-1){~sa_reg}}} : res_next;
`else
  assign sum_next = res_next;
`endif

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      cnt_reg   <= '0;
      sum       <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= sub;
            cnt_reg   <= '0;
            sa_reg    <= a[WIDTH-1];
            sb_reg    <= b_eff[WIDTH-1];
          end
        end
        RUN: begin
          a_reg     <= a_reg >> CHUNK;
          b_reg     <= b_reg >> CHUNK;
          res_reg   <= res_next;
          carry_reg <= chunk_sum[CHUNK];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_chunk) begin
            sum      <= sum_next;
            carryout <= chunk_sum[CHUNK];
            overflow <= raw_ov;
            zero     <= (sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: three configurations (8/4, 8/1, 16/16) checked against an arithmetic model.
module tb_chunked_addsub;

  localparam int NI = 3;

  function automatic int w_of(int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic int c_of(int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start [NI];
  logic        sub_i [NI];
  logic [15:0] a_i   [NI];
  logic [15:0] b_i   [NI];
  logic        busy_o[NI];
  logic        done_o[NI];
  logic        co_o  [NI];
  logic        ov_o  [NI];
  logic        z_o   [NI];
  logic [15:0] sum_o [NI];

  int   cyc = 0;
  int   free_at[NI] = '{0, 0, 0};
  int   bf     [NI] = '{0, 0, 0};
  int   bt     [NI] = '{-1, -1, -1};
  int   done_at[NI] = '{-1, -1, -1};
  res_t last_r [NI];
  res_t exp_q  [NI][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int W = w_of(gi);
      localparam int C = c_of(gi);
      logic [W-1:0] s;
      chunked_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start[gi]),
        .sub     (sub_i[gi]),
        .a       (a_i[gi][W-1:0]),
        .b       (b_i[gi][W-1:0]),
        .busy    (busy_o[gi]),
        .done    (done_o[gi]),
        .sum     (s),
        .carryout(co_o[gi]),
        .overflow(ov_o[gi]),
        .zero    (z_o[gi])
      );
      assign sum_o[gi] = 16'(s);
    end
  endgenerate

  // Plain integer arithmetic: unsigned for sum/carry, signed range test for overflow.
  function automatic res_t model(int k, logic [15:0] a, logic [15:0] b, logic sub);
    res_t   r;
    longint m    = longint'(1) << w_of(k);
    longint ua   = longint'(a) & (m - 1);
    longint ub   = longint'(b) & (m - 1);
    longint raw  = sub ? ua - ub : ua + ub;
    longint wrap = ((raw % m) + m) % m;
    longint sa   = (ua >= m / 2) ? ua - m : ua;
    longint sb   = (ub >= m / 2) ? ub - m : ub;
    longint sr   = sub ? sa - sb : sa + sb;
    logic   ov   = (sr > m / 2 - 1) || (sr < -(m / 2));
`ifdef SATURATE_EN
    if (ov) wrap = (sr > 0) ? m / 2 - 1 : m / 2;
`endif
    r.sum = 16'(wrap);
    r.co  = sub ? (ua >= ub) : (raw >= m);
    r.ov  = ov;
    r.z   = (wrap == 0);
    return r;
  endfunction

  task automatic chk(string name, int k, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic observe(int k, int e);
    int n;
    n = w_of(k) / c_of(k);
    if (!reset_n) begin
      free_at[k] = 0;
      bf[k]      = 0;
      bt[k]      = -1;
      done_at[k] = -1;
    end else if (start[k] && e >= free_at[k]) begin
      exp_q[k].push_back(model(k, a_i[k], b_i[k], sub_i[k]));
      free_at[k] = e + n + 2;
      bf[k]      = e;
      bt[k]      = e + n;
      done_at[k] = e + n;
    end
  endtask

  task automatic monitor_step(int k);
    logic exp_busy, exp_done;
    if (!reset_n) begin
      last_r[k] = '0;
      exp_q[k].delete();
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_busy = (cyc >= bf[k]) && (cyc <= bt[k]);
      exp_done = (cyc == done_at[k]);
      if (exp_done) begin
        if (exp_q[k].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard inst%0d cycle %0d: got empty queue expected an entry", k, cyc);
        end else begin
          last_r[k] = exp_q[k].pop_front();
        end
        $display("cycle %0d inst%0d done: sum=%h co=%b ov=%b z=%b (model sum=%h co=%b ov=%b z=%b)",
                 cyc, k, sum_o[k], co_o[k], ov_o[k], z_o[k],
                 last_r[k].sum, last_r[k].co, last_r[k].ov, last_r[k].z);
      end
    end
    chk("busy", k, 16'(busy_o[k]), 16'(exp_busy));
    chk("done", k, 16'(done_o[k]), 16'(exp_done));
    chk("sum", k, sum_o[k], last_r[k].sum);
    chk("carryout", k, 16'(co_o[k]), 16'(last_r[k].co));
    chk("overflow", k, 16'(ov_o[k]), 16'(last_r[k].ov));
    chk("zero", k, 16'(z_o[k]), 16'(last_r[k].z));
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) observe(k, cyc + 1);
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) monitor_step(k);
  end

  task automatic do_op(int k, logic [15:0] a, logic [15:0] b, logic sub);
    @(negedge clk);
    while (cyc + 1 < free_at[k]) @(negedge clk);
    start[k] = 1'b1;
    a_i[k]   = a;
    b_i[k]   = b;
    sub_i[k] = sub;
    @(negedge clk);
    start[k] = 1'b0;
    a_i[k]   = 16'($urandom);
    b_i[k]   = 16'($urandom);
    sub_i[k] = 1'($urandom);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      start[k]  = 1'b0;
      sub_i[k]  = 1'b0;
      a_i[k]    = '0;
      b_i[k]    = '0;
      last_r[k] = '0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    do_op(0, 16'h05, 16'h09, 1'b0);
    do_op(0, 16'h7F, 16'h01, 1'b0);
    do_op(0, 16'h05, 16'h09, 1'b1);
    do_op(0, 16'h09, 16'h09, 1'b1);
    do_op(0, 16'h80, 16'h01, 1'b1);
    do_op(1, 16'hFF, 16'hFF, 1'b0);
    do_op(1, 16'h40, 16'h40, 1'b0);
    do_op(2, 16'h8000, 16'h8000, 1'b0);
    do_op(2, 16'h7FFF, 16'h8000, 1'b1);
    do_op(2, 16'h1234, 16'h1234, 1'b1);

    for (int i = 0; i < 20; i++)
      for (int k = 0; k < NI; k++)
        do_op(k, 16'($urandom), 16'($urandom), 1'($urandom));

    // start held high while operands churn: only values present at acceptance edges count
    @(negedge clk);
    while (cyc + 1 < free_at[0]) @(negedge clk);
    start[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a_i[0]   = 16'($urandom);
      b_i[0]   = 16'($urandom);
      sub_i[0] = 1'($urandom);
      @(negedge clk);
    end
    start[0] = 1'b0;
    repeat (6) @(negedge clk);

    // reset mid-RUN: outputs clear at once and no done follows
    do_op(0, 16'h12, 16'h34, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", k, 16'(busy_o[k]), 16'h0);
      chk("rst_done", k, 16'(done_o[k]), 16'h0);
      chk("rst_sum", k, sum_o[k], 16'h0);
      chk("rst_flags", k, {13'h0, co_o[k], ov_o[k], z_o[k]}, 16'h0);
    end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    do_op(0, 16'h7F, 16'h7F, 1'b0);
    do_op(0, 16'h33, 16'h44, 1'b1);

    repeat (24) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain inst%0d: got %0d outstanding results expected 0", k, exp_q[k].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised multi-cycle adder/subtractor generalising the four-bit ripple adder to WIDTH-bit operands. CHUNK bits are resolved per clock, least significant chunk first, with the carry held in a register between chunks. The block uses a start/done handshake and reports carryout, signed overflow and zero. It serves as the shared arithmetic unit for the lab datapath, where area matters more than single-cycle latency.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per clock cycle, 1..WIDTH. Define N = WIDTH/CHUNK.
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only while idle.
- sub  input  1  0: a+b; 1: a−b. Latched with the operands.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result.
- carryout  output  1  carry out of the MSB. For subtraction, 1 means no borrow (a ≥ b unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - When start=1 at an edge: latch a into the A shift register and (sub ? ~b : b) into the B shift register.
  - Set the carry register to sub, set the chunk counter to 0, latch sign bits a[WIDTH-1] and b'[WIDTH-1], then go to RUN.
  - When start=0: stay in IDLE.
- **RUN**
  - Each edge adds the low CHUNK bits of A, B and the carry register.
  - The chunk result shifts into the top of the result shift register. A and B shift right by CHUNK. The carry register takes the chunk carry. The counter increments.
  - On the edge where counter == N−1, go to DONE, load sum, carryout, overflow and zero, and assert done.
- **DONE**: lasts one cycle, then unconditionally returns to IDLE.
- start is ignored in RUN and DONE. Changes on a, b or sub after acceptance have no effect.
- overflow = (sa == sb') && (sum[WIDTH-1] != sa), where sa is the sign of a and sb' is the sign of b after optional inversion.
- sum, carryout, overflow and zero hold their last values until the next DONE entry. Only done pulses.
- CHUNK == WIDTH is legal: N = 1, a single RUN cycle.

## Timing
- Reset values, asynchronous on reset_n low: state IDLE, busy 0, done 0, sum 0, carryout 0, overflow 0, zero 0, internal registers 0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; no done is produced.
- A start accepted at edge E gives:
  - busy high from E to E+N+1;
  - done high for exactly the cycle between edges E+N and E+N+1.
- Latency is N cycles. Throughput is one operation per N+2 cycles: the earliest next acceptance is edge E+N+2.
- Wrap-around: without saturation, results are modulo 2^WIDTH.

## Configuration
- SATURATE_EN:
  - **Defined:** on signed overflow, sum is forced to the signed extreme in the direction of the operands' common sign: 0111…1 if sa = 0, 1000…0 if sa = 1.
    - overflow is still reported as 1.
    - carryout is unchanged (raw carry).
    - zero is computed on the saturated value.
  - **Undefined:** sum is the raw wrapped result. No saturation logic is synthesised.

## Test plan
- WIDTH=8, CHUNK=4, sub=0, a=0x05, b=0x09, start for one cycle:
  - done exactly 2 cycles after acceptance, busy high for 3 cycles;
  - sum=0x0E, carryout=0, overflow=0, zero=0.
- WIDTH=8, CHUNK=4, a=0x7F, b=0x01, add: overflow=1, carryout=0; sum=0x80 (0x7F with SATURATE_EN).
- WIDTH=8, CHUNK=4, sub=1:
  - a=0x05, b=0x09 gives sum=0xFC, carryout=0, overflow=0;
  - a=0x09, b=0x09 gives sum=0x00, carryout=1, zero=1.
- WIDTH=8, CHUNK=1, a=0xFF, b=0xFF, add: done 8 cycles after acceptance, sum=0xFE, carryout=1, overflow=0.
- Protocol and reset:
  - start held high with operands changed during RUN: result reflects only the accepted operands, and the second acceptance occurs no earlier than E+N+2;
  - reset_n pulsed low mid-RUN: all outputs go to 0 at once, no done pulse, and the next start completes correctly.
- WIDTH=16, CHUNK=16, a=0x8000, b=0x8000, add: done 1 cycle after acceptance, sum=0x0000, carryout=1, overflow=1, zero=1 (sum=0x8000, zero=0 with SATURATE_EN).
